// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe_pkg: shared ISA constants for the immediate generator.
//   - RV opcode constants, including OP_IMM_32, OP_32 and OP_SYSTEM.
//   - imm_fmt_e: 3-bit format tag carried on out_fmt.
package imm_gen_pipe_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_FMT_NONE = 3'd0,
        IMM_FMT_I    = 3'd1,
        IMM_FMT_S    = 3'd2,
        IMM_FMT_B    = 3'd3,
        IMM_FMT_U    = 3'd4,
        IMM_FMT_J    = 3'd5,
        IMM_FMT_Z    = 3'd6
    } imm_fmt_e;

endpackage

// File: rtl/imm_gen_pipe_skid.sv
// imm_gen_pipe_skid: 2-entry valid/ready register (output stage + skid entry).
//   clk/rst      : clock, synchronous active-high reset
//   flush        : drop all held entries and any incoming entry this cycle
//   in_valid/in_ready/in_data    : upstream handshake; in_ready = !skid_full
//   out_valid/out_ready/out_data : downstream handshake
module imm_gen_pipe_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic         r_skid_full;
    logic [W-1:0] r_skid_data;
    logic         w_in_hs;
    logic         w_out_free;

    assign w_in_hs    = in_valid & ~r_skid_full;
    // Output slot can be (re)loaded when empty or being drained this cycle.
    assign w_out_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_skid_full <= 1'b0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (w_out_free) begin
            // A full skid implies in_ready=0, so no new entry competes here.
            if (r_skid_full) begin
                r_out_data  <= r_skid_data;
                r_out_valid <= 1'b1;
                r_skid_full <= 1'b0;
            end else if (w_in_hs) begin
                r_out_data  <= in_data;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_hs) begin
            r_skid_data <= in_data;
            r_skid_full <= 1'b1;
        end
    end

    assign in_ready  = ~r_skid_full;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered, flow-controlled RV immediate generator.
//   Decodes {in_instr, in_pc} and emits sign-extended immediate, format tag,
//   illegal flag and pc one cycle after the input handshake.
//   clk, rst (sync active-high), flush
//   in_valid/in_ready/in_instr[31:0]/in_pc[PC_W-1:0]
//   out_valid/out_ready/out_imm[XLEN-1:0]/out_fmt[2:0]/out_illegal/out_pc
//   Optional: define IMM_GEN_ZICSR_EN to decode SYSTEM as I / Z (CSR imm).
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc
);

    localparam int unsigned PAY_W = XLEN + 3 + 1 + PC_W;

    imm_fmt_e          w_fmt;
    logic              w_illegal;
    logic [XLEN-1:0]   w_imm;
    logic [PAY_W-1:0]  w_in_data;
    logic [PAY_W-1:0]  w_out_data;

    always_comb begin
        w_fmt     = IMM_FMT_NONE;
        w_illegal = 1'b0;
        case (in_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: w_fmt = IMM_FMT_I;
            OP_IMM_32: begin
                if (XLEN == 64) w_fmt = IMM_FMT_I;
                else            w_illegal = 1'b1;
            end
            OP_STORE:          w_fmt = IMM_FMT_S;
            OP_BRANCH:         w_fmt = IMM_FMT_B;
            OP_LUI, OP_AUIPC:  w_fmt = IMM_FMT_U;
            OP_JAL:            w_fmt = IMM_FMT_J;
            OP_OP, OP_32: begin
                w_fmt = IMM_FMT_NONE;
            end
            OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                // funct3[2] selects the immediate CSR forms (uimm in rs1 field).
                w_fmt = in_instr[14] ? IMM_FMT_Z : IMM_FMT_I;
`else
                w_fmt = IMM_FMT_NONE;
`endif
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_imm = '0;
        case (w_fmt)
            IMM_FMT_I: w_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            IMM_FMT_S: w_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            IMM_FMT_B: w_imm = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0};
            // Sign taken from bit 31 so the fill is non-empty even for XLEN=32.
            IMM_FMT_U: w_imm = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'h000};
            IMM_FMT_J: w_imm = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0};
            IMM_FMT_Z: w_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
            default:   w_imm = '0;
        endcase
    end

    assign w_in_data = {w_imm, w_fmt, w_illegal, in_pc};

    imm_gen_pipe_skid #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data)
    );

    assign {out_imm, out_fmt, out_illegal, out_pc} = w_out_data;

endmodule
